// File: rtl/fproc_meas_pkg.sv
// Shared types and constants for the measurement-feedback buffer.
package fproc_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } meas_state_e;

  localparam logic MODE_NEXT   = 1'b0;
  localparam logic MODE_LATEST = 1'b1;

  // Response flag positions sit at the top of the data word.
  function automatic int unsigned timeout_bit(input int unsigned dw);
    return dw - 1;
  endfunction

  function automatic int unsigned badaddr_bit(input int unsigned dw);
    return dw - 2;
  endfunction

endpackage

// File: rtl/fproc_iface.sv
// Request/response link between a processor core and the function processor.
interface fproc_iface #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 16
);
  logic                  enable;
  logic [ID_WIDTH-1:0]   id;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport fproc (input enable, input id, output ready, output data);
  modport core  (output enable, output id, input ready, input data);
endinterface

// File: rtl/fproc_meas_chan.sv
// Per-core request FSM: IDLE -> (WAIT) -> RESP, with optional timeout.
module fproc_meas_chan
  import fproc_meas_pkg::*;
#(
  parameter int unsigned N_MEAS         = 5,
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned MEAS_WIDTH     = 1,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  mode,
  output logic [ADDR_W-1:0]     sel_addr_c,
  input  logic                  sel_valid,
  input  logic [MEAS_WIDTH-1:0] sel_meas,
  input  logic                  sel_lat_val,
  input  logic [MEAS_WIDTH-1:0] sel_lat_data,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_BIT = timeout_bit(DATA_WIDTH);
  localparam int unsigned BA_BIT = badaddr_bit(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  meas_state_e           state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  bad_addr;

  assign bad_addr   = (32'(addr) >= N_MEAS);
  // While idle the live request address steers the mux; afterwards the captured one.
  assign sel_addr_c = (state_q == ST_IDLE) ? addr : addr_q;

  // State, counter and registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ready   <= 1'b0;
      data    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ready   <= (state_d == ST_RESP);
      data    <= data_d;
    end
  end

  // Next-state and response payload selection.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          addr_d = addr;
          cnt_d  = '0;
          if (bad_addr) begin
            state_d        = ST_RESP;
            data_d[BA_BIT] = 1'b1;
          end else if (sel_valid) begin
            state_d = ST_RESP;
            data_d  = DATA_WIDTH'(sel_meas);
          end else if ((mode == MODE_LATEST) && sel_lat_val) begin
            state_d = ST_RESP;
            data_d  = DATA_WIDTH'(sel_lat_data);
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (sel_valid) begin
          state_d = ST_RESP;
          data_d  = DATA_WIDTH'(sel_meas);
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d        = ST_RESP;
          data_d[TO_BIT] = 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/fproc_meas_buf.sv
// Latches every measurement channel and serves per-core feedback requests.
module fproc_meas_buf #(
  parameter int unsigned N_CORES        = 5,
  parameter int unsigned N_MEAS         = N_CORES,
  parameter int unsigned MEAS_WIDTH     = 1,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned MODE_BIT       = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_MEAS*MEAS_WIDTH-1:0] meas,
  input  logic [N_MEAS-1:0]            meas_valid,
  input  logic [N_MEAS-1:0]            meas_clear,
  fproc_iface.fproc                    core [N_CORES-1:0]
);

  localparam int unsigned ADDR_W = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;
  localparam int unsigned N_PAD  = 1 << ADDR_W;

  logic [N_MEAS-1:0]     lat_val;
  logic [MEAS_WIDTH-1:0] lat_data [N_MEAS];

  // Padded views so any address value indexes a defined entry.
  logic [N_PAD-1:0]      valid_pad;
  logic [N_PAD-1:0]      lat_val_pad;
  logic [MEAS_WIDTH-1:0] meas_pad     [N_PAD];
  logic [MEAS_WIDTH-1:0] lat_data_pad [N_PAD];

  for (genvar k = 0; k < N_MEAS; k++) begin : g_lat
    // Channel latch: a new result beats a clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        lat_val[k]  <= 1'b0;
        lat_data[k] <= '0;
      end else if (meas_valid[k]) begin
        lat_val[k]  <= 1'b1;
        lat_data[k] <= meas[k*MEAS_WIDTH +: MEAS_WIDTH];
      end else if (meas_clear[k]) begin
        lat_val[k]  <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < N_PAD; k++) begin : g_pad
    if (k < N_MEAS) begin : g_real
      assign valid_pad[k]    = meas_valid[k];
      assign lat_val_pad[k]  = lat_val[k];
      assign meas_pad[k]     = meas[k*MEAS_WIDTH +: MEAS_WIDTH];
      assign lat_data_pad[k] = lat_data[k];
    end else begin : g_zero
      assign valid_pad[k]    = 1'b0;
      assign lat_val_pad[k]  = 1'b0;
      assign meas_pad[k]     = '0;
      assign lat_data_pad[k] = '0;
    end
  end

  for (genvar i = 0; i < N_CORES; i++) begin : g_core
    logic [ADDR_W-1:0] sel_addr;

    fproc_meas_chan #(
      .N_MEAS         (N_MEAS),
      .ADDR_W         (ADDR_W),
      .MEAS_WIDTH     (MEAS_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .enable       (core[i].enable),
      .addr         (core[i].id[ADDR_W-1:0]),
      .mode         (core[i].id[MODE_BIT]),
      .sel_addr_c   (sel_addr),
      .sel_valid    (valid_pad[sel_addr]),
      .sel_meas     (meas_pad[sel_addr]),
      .sel_lat_val  (lat_val_pad[sel_addr]),
      .sel_lat_data (lat_data_pad[sel_addr]),
      .ready        (core[i].ready),
      .data         (core[i].data)
    );
  end

endmodule

// File: tb/tb_fproc_meas_buf.sv
// Directed bench for fproc_meas_buf: 5 cores, 5 channels, 4-bit results, timeout 8.
module tb_fproc_meas_buf;

  localparam int unsigned NC = 5;
  localparam int unsigned NM = 5;
  localparam int unsigned MW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic                 clk;
  logic                 reset;
  logic [NM*MW-1:0]     meas;
  logic [NM-1:0]        meas_valid;
  logic [NM-1:0]        meas_clear;

  logic                 en  [NC];
  logic [15:0]          id  [NC];
  logic                 rdy [NC];
  logic [DW-1:0]        dat [NC];

  int total;
  int bad;

  fproc_iface #(.DATA_WIDTH(DW), .ID_WIDTH(16)) core_if [NC-1:0] ();

  for (genvar g = 0; g < NC; g++) begin : g_bridge
    assign core_if[g].enable = en[g];
    assign core_if[g].id     = id[g];
    assign rdy[g]            = core_if[g].ready;
    assign dat[g]            = core_if[g].data;
  end

  fproc_meas_buf #(
    .N_CORES        (NC),
    .N_MEAS         (NM),
    .MEAS_WIDTH     (MW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO),
    .MODE_BIT       (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .meas       (meas),
    .meas_valid (meas_valid),
    .meas_clear (meas_clear),
    .core       (core_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int ch, input logic [MW-1:0] v);
    meas_valid     = '0;
    meas_valid[ch] = 1'b1;
    meas[ch*MW +: MW] = v;
  endtask

  task automatic idle_inputs();
    meas_valid = '0;
    meas_clear = '0;
    for (int i = 0; i < NC; i++) en[i] = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    meas  = '0;
    idle_inputs();
    for (int i = 0; i < NC; i++) id[i] = '0;
    tick();
    tick();
    for (int i = 0; i < NC; i++) begin
      check($sformatf("rst_rdy%0d", i), 32'(rdy[i]), 32'h0);
      check($sformatf("rst_dat%0d", i), dat[i], 32'h0);
    end
    reset = 1'b1;
    tick();

    // NEXT wait: strobe 5 cycles after the request.
    en[0] = 1'b1; id[0] = 16'h0002;
    tick();
    en[0] = 1'b0;
    check("next_wait0", 32'(rdy[0]), 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check("next_wait1", 32'(rdy[0]), 32'h0);
    strobe(2, 4'h1);
    tick();
    idle_inputs();
    check("next_rdy", 32'(rdy[0]), 32'h1);
    check("next_dat", dat[0], 32'h0000_0001);
    tick();
    check("next_rdy_drop", 32'(rdy[0]), 32'h0);
    check("next_dat_drop", dat[0], 32'h0);

    // LATEST hit after storing 0xA on channel 1.
    strobe(1, 4'hA);
    tick();
    idle_inputs();
    for (int i = 0; i < 10; i++) tick();
    en[3] = 1'b1; id[3] = 16'h0101;
    tick();
    en[3] = 1'b0;
    check("latest_rdy", 32'(rdy[3]), 32'h1);
    check("latest_dat", dat[3], 32'h0000_000A);
    tick();
    // NEXT on the same channel must wait instead.
    en[3] = 1'b1; id[3] = 16'h0001;
    tick();
    en[3] = 1'b0;
    check("next_no_hit", 32'(rdy[3]), 32'h0);
    tick();
    check("next_no_hit2", 32'(rdy[3]), 32'h0);
    strobe(1, 4'h3);
    tick();
    idle_inputs();
    check("next_ch1_rdy", 32'(rdy[3]), 32'h1);
    check("next_ch1_dat", dat[3], 32'h0000_0003);
    tick();

    // Clear makes LATEST wait; clear+valid together keeps the new value.
    meas_clear[1] = 1'b1;
    tick();
    idle_inputs();
    en[1] = 1'b1; id[1] = 16'h0101;
    tick();
    en[1] = 1'b0;
    check("clr_latest_wait", 32'(rdy[1]), 32'h0);
    strobe(1, 4'h5);
    meas_clear[1] = 1'b1;
    tick();
    idle_inputs();
    check("clr_wait_rdy", 32'(rdy[1]), 32'h1);
    check("clr_wait_dat", dat[1], 32'h0000_0005);
    en[2] = 1'b1; id[2] = 16'h0101;
    tick();
    en[2] = 1'b0;
    check("clrvalid_rdy", 32'(rdy[2]), 32'h1);
    check("clrvalid_dat", dat[2], 32'h0000_0005);
    tick();

    // Same-cycle strobe on an idle request answers at t+1.
    en[0] = 1'b1; id[0] = 16'h0004;
    strobe(4, 4'h9);
    tick();
    idle_inputs();
    check("same_cyc_rdy", 32'(rdy[0]), 32'h1);
    check("same_cyc_dat", dat[0], 32'h0000_0009);
    tick();

    // Timeout: ready at t+9 with the timeout flag.
    en[4] = 1'b1; id[4] = 16'h0003;
    tick();
    en[4] = 1'b0;
    for (int k = 2; k <= 8; k++) tick();
    check("to_early", 32'(rdy[4]), 32'h0);
    tick();
    check("to_rdy", 32'(rdy[4]), 32'h1);
    check("to_dat", dat[4], 32'h8000_0000);
    tick();

    // Strobe in the last wait cycle beats the timeout.
    en[4] = 1'b1; id[4] = 16'h0003;
    tick();
    en[4] = 1'b0;
    for (int k = 2; k <= 8; k++) tick();
    strobe(3, 4'h6);
    tick();
    idle_inputs();
    check("to_race_rdy", 32'(rdy[4]), 32'h1);
    check("to_race_dat", dat[4], 32'h0000_0006);
    tick();

    // Bad addresses: 7 and the first out-of-range value 5.
    en[0] = 1'b1; id[0] = 16'h0007;
    tick();
    en[0] = 1'b0;
    check("bad7_rdy", 32'(rdy[0]), 32'h1);
    check("bad7_dat", dat[0], 32'h4000_0000);
    tick();
    en[0] = 1'b1; id[0] = 16'h0105;
    tick();
    en[0] = 1'b0;
    check("bad5_dat", dat[0], 32'h4000_0000);
    tick();

    // Fan-out: five cores waiting on channel 0, one strobe answers all.
    for (int i = 0; i < NC; i++) begin
      en[i] = 1'b1; id[i] = 16'h0000;
    end
    tick();
    idle_inputs();
    check("fan_wait", 32'(rdy[2]), 32'h0);
    tick();
    strobe(0, 4'h1);
    tick();
    idle_inputs();
    for (int i = 0; i < NC; i++) begin
      check($sformatf("fan_rdy%0d", i), 32'(rdy[i]), 32'h1);
      check($sformatf("fan_dat%0d", i), dat[i], 32'h0000_0001);
    end
    tick();

    // Async reset mid-WAIT, then no stale response and latches cleared.
    en[0] = 1'b1; id[0] = 16'h0004;
    tick();
    en[0] = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_rdy", 32'(rdy[0]), 32'h0);
    check("arst_dat", dat[0], 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    strobe(4, 4'h2);
    tick();
    idle_inputs();
    check("arst_no_resp", 32'(rdy[0]), 32'h0);
    check("arst_no_dat", dat[0], 32'h0);
    en[2] = 1'b1; id[2] = 16'h0101;
    tick();
    en[2] = 1'b0;
    check("arst_lat_clr", 32'(rdy[2]), 32'h0);
    tick();
    check("arst_lat_clr2", 32'(rdy[2]), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
